spm_program_loader: RTL

//  Host-side writer for the RISC SPM memory unit: accepts a byte stream over a valid/ready

---
 rtl/spm_pkg.sv | 28 ++
 rtl/spm_program_loader.sv | 114 +++++++++++
 2 files changed

// File: rtl/spm_pkg.sv
// Shared RISC SPM definitions: default word/address widths and the program
// loader state encoding, plus the rule for leaving a completed byte write.
package spm_pkg;

  localparam int spm_word_size = 8;
  localparam int spm_addr_size = 8;

  typedef enum logic [2:0] {
    LD_IDLE  = 3'd0,
    LD_LOAD  = 3'd1,
    LD_WRITE = 3'd2,
    LD_CHECK = 3'd3,
    LD_DONE  = 3'd4,
    LD_ERR   = 3'd5
  } loader_state_t;

  // A final byte always completes the image, even at the top address; otherwise
  // running into the top address is an overflow because the address never wraps.
  function automatic loader_state_t after_write(input logic is_last, input logic at_top);
    if (is_last)
      return LD_DONE;
    else if (at_top)
      return LD_ERR;
    else
      return LD_LOAD;
  endfunction

endpackage

// File: rtl/spm_program_loader.sv
// Host-to-memory image loader for the RISC SPM; holds the CPU in reset until the image is in.
// Optional read-back check of every written byte is enabled with `define LOADER_VERIFY_EN.
module spm_program_loader
  import spm_pkg::*;
#(
  parameter int word_size = spm_word_size,
  parameter int addr_size = spm_addr_size,
  parameter int load_base = 0,
  parameter int mem_depth = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [word_size-1:0] host_data,
  input  logic                 host_valid,
  input  logic                 host_last,
  output logic                 host_ready,
  output logic [addr_size-1:0] mem_address,
  output logic [word_size-1:0] mem_data_in,
  output logic                 mem_write,
  input  logic [word_size-1:0] mem_word,
  output logic                 cpu_rst,
  output logic                 done,
  output logic                 error,
  output logic [addr_size:0]   byte_count
);

  localparam logic [addr_size-1:0] base_addr = addr_size'(load_base);
  localparam logic [addr_size-1:0] top_addr  = addr_size'(mem_depth - 1);

  loader_state_t state, state_d;
  logic [addr_size-1:0] address_d;
  logic [word_size-1:0] data_d;
  logic [addr_size:0]   count_d;
  logic                 last_q, last_d;

`ifndef LOADER_VERIFY_EN
  logic unused_mem_word;
  assign unused_mem_word = ^mem_word;
`endif

  always_comb begin
    state_d   = state;
    address_d = mem_address;
    data_d    = mem_data_in;
    count_d   = byte_count;
    last_d    = last_q;
    case (state)
      LD_IDLE, LD_DONE, LD_ERR: begin
        if (start) begin
          state_d   = LD_LOAD;
          address_d = base_addr;
          count_d   = '0;
        end
      end
      LD_LOAD: begin
        if (host_valid && host_ready) begin
          state_d = LD_WRITE;
          data_d  = host_data;
          last_d  = host_last;
        end
      end
      LD_WRITE: begin
        count_d = byte_count + (addr_size + 1)'(1);
`ifdef LOADER_VERIFY_EN
        state_d = LD_CHECK;
`else
        state_d   = after_write(last_q, mem_address == top_addr);
        address_d = mem_address + addr_size'(1);
`endif
      end
`ifdef LOADER_VERIFY_EN
      // Memory has absorbed the write by now, so its read port shows the stored byte.
      LD_CHECK: begin
        if (mem_word != mem_data_in) begin
          state_d = LD_ERR;
        end else begin
          state_d   = after_write(last_q, mem_address == top_addr);
          address_d = mem_address + addr_size'(1);
        end
      end
`endif
      default: state_d = LD_IDLE;
    endcase
  end

  // Status outputs are registered straight from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= LD_IDLE;
      mem_address <= '0;
      mem_data_in <= '0;
      byte_count  <= '0;
      last_q      <= 1'b0;
      host_ready  <= 1'b0;
      mem_write   <= 1'b0;
      cpu_rst     <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      state       <= state_d;
      mem_address <= address_d;
      mem_data_in <= data_d;
      byte_count  <= count_d;
      last_q      <= last_d;
      host_ready  <= (state_d == LD_LOAD);
      mem_write   <= (state_d == LD_WRITE);
      cpu_rst     <= (state_d == LD_DONE);
      done        <= (state_d == LD_DONE);
      error       <= (state_d == LD_ERR);
    end
  end

endmodule
